// File: rtl/mux8_rr_arbiter.sv
// rtl/mux8_rr_arbiter.sv - round-robin owner arbiter driving a registered 8:1 mux select
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t     state, state_n;
  logic [7:0] grant_n;
  logic [2:0] sel_n;
  logic [2:0] last, last_n;
  logic [7:0] hold, hold_n;
  logic       timeout_n;

  logic [2:0] win;
  logic [2:0] idx;
  logic       found;
  logic       any_req;
  logic       expired;
  logic       withdrawn;
  logic       release_now;

  assign any_req     = |req;
  assign expired     = (hold == 8'(MAX_HOLD));
  assign withdrawn   = ~req[sel];
  assign release_now = done | withdrawn | expired;
  assign busy        = (state != IDLE);

  // Search starts one past the previous owner, so that owner comes last (i=8 wraps to it).
  always_comb begin
    win   = last;
    idx   = last;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = last + 3'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n   = state;
    grant_n   = grant;
    sel_n     = sel;
    last_n    = last;
    hold_n    = hold;
    timeout_n = 1'b0;
    case (state)
      IDLE, GAP: begin
        if (any_req) begin
          state_n = GRANT;
          grant_n = 8'(1) << win;
          sel_n   = win;
          hold_n  = 8'd1;
        end else begin
          state_n = IDLE;
          grant_n = 8'h00;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_n   = GAP;
          grant_n   = 8'h00;
          last_n    = sel;
          hold_n    = 8'd0;
          // Expiry only counts as a timeout when nothing else ended the grant.
          timeout_n = expired & ~done & ~withdrawn;
        end else begin
          hold_n = hold + 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= 8'h00;
      sel     <= 3'd0;
      last    <= 3'd7;
      hold    <= 8'd0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      grant   <= grant_n;
      sel     <= sel_n;
      last    <= last_n;
      hold    <= hold_n;
      timeout <= timeout_n;
    end
  end

endmodule
